// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nibbles);
    int w;
    w = $clog2(nibbles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Start/busy/done request bus between the control unit and the serial add/sub sequencer.
interface serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  import serial_addsub_pkg::*;

  localparam int WIDTH = NIBBLE_W * NIBBLES;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, carry_out, overflow
  );

endinterface

// File: rtl/serial_addsub_ctrl_nibble_addsub.sv
// One 4-bit add/subtract slice; operand inversion and carry-in are separate controls.
module nibble_addsub
  import serial_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b_eff_s;
  logic [NIBBLE_W:0]   total_s;

  // Slice arithmetic: a + (b ^ {sub}) + cin with the carry kept as the extra bit.
  always_comb begin
    b_eff_s = b ^ {NIBBLE_W{sub}};
    total_s = {1'b0, a} + {1'b0, b_eff_s} + {{NIBBLE_W{1'b0}}, cin};
    sum     = total_s[NIBBLE_W-1:0];
    cout    = total_s[NIBBLE_W];
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor: one shared 4-bit slice, LS nibble first,
// carry held in a register between nibbles, start/busy/done handshake.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_addsub_ctrl_if.slave bus
);

  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                             state_q;
  logic [IDX_W-1:0]                   idx_q;
  logic                               carry_q;
  logic                               sub_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   result_q;
  logic                               busy_q;
  logic                               done_q;
  logic                               carry_out_q;
  logic                               overflow_q;

  logic [NIBBLE_W-1:0] a_nib_s;
  logic [NIBBLE_W-1:0] b_nib_s;
  logic [NIBBLE_W-1:0] sum_s;
  logic                cout_s;
  logic                last_s;
  logic                overflow_d;
  logic [IDX_W-1:0]    idx_d;

  // Operand nibble selection and end-of-operation decode for the current RUN cycle.
  always_comb begin
    a_nib_s    = a_q[idx_q];
    b_nib_s    = b_q[idx_q];
    last_s     = (idx_q == LAST_IDX);
    idx_d      = idx_q + IDX_W'(1);
    // Signed overflow: operands agree in sign after inversion, sum sign differs.
    overflow_d = (a_q[NIBBLES-1][NIBBLE_W-1] == (b_q[NIBBLES-1][NIBBLE_W-1] ^ sub_q)) &&
                 (sum_s[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
  end

  nibble_addsub u_slice (
    .a    (a_nib_s),
    .b    (b_nib_s),
    .sub  (sub_q),
    .cin  (carry_q),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.op_a;
            b_q      <= bus.op_b;
            sub_q    <= bus.sub;
            carry_q  <= bus.sub;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          result_q[idx_q] <= sum_s;
          carry_q         <= cout_s;
          if (last_s) begin
            carry_out_q <= cout_s;
            overflow_q  <= overflow_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q       <= idx_d;
            state_q     <= RUN;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed cases plus randomized operations vs. an arithmetic model.
module tb_serial_addsub_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  localparam longint MOD  = 64'd1 << W;
  localparam longint HALF = 64'd1 << (W - 1);

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  serial_addsub_ctrl_if #(.NIBBLES(NIB)) bus ();

  serial_addsub_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic s, input longint a, input longint b,
                       output longint r, output longint c, output longint v);
    longint sa, sb, sres;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    if (s) begin
      r    = (a - b + MOD) % MOD;
      c    = (a >= b) ? 1 : 0;
      sres = sa - sb;
    end else begin
      r    = (a + b) % MOD;
      c    = ((a + b) >= MOD) ? 1 : 0;
      sres = sa + sb;
    end
    v = (sres >= HALF || sres < -HALF) ? 1 : 0;
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke_run, input bit poke_done);
    longint er, ec, ev;
    int busy_cnt, done_cnt;
    model(s, longint'(a), longint'(b), er, ec, ev);
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.sub = s; bus.op_a = a; bus.op_b = b;
    for (int k = 1; k <= NIB + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_eq("result_cleared", longint'(bus.result), 0);
        bus.start = 1'b0;
        bus.sub   = 1'($urandom);
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
      end
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      if (k == NIB + 1) begin
        check_eq("done_at_latency", longint'(bus.done), 1);
        check_eq("result", longint'(bus.result), er);
        check_eq("carry_out", longint'(bus.carry_out), ec);
        check_eq("overflow", longint'(bus.overflow), ev);
      end
      if (poke_run && k == 2) begin
        bus.start = 1'b1; bus.op_a = 16'hAAAA; bus.op_b = 16'h5555;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = poke_done;
    bus.op_a  = W'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt += int'(bus.done);
    check_eq("busy_cycles", longint'(busy_cnt), NIB);
    check_eq("done_pulses", longint'(done_cnt), 1);
    check_eq("idle_busy", longint'(bus.busy), 0);
    check_eq("result_hold", longint'(bus.result), er);
    check_eq("carry_hold", longint'(bus.carry_out), ec);
    check_eq("overflow_hold", longint'(bus.overflow), ev);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", longint'(bus.busy), 0);
    check_eq("rst_done", longint'(bus.done), 0);
    check_eq("rst_result", longint'(bus.result), 0);
    check_eq("rst_carry", longint'(bus.carry_out), 0);
    check_eq("rst_overflow", longint'(bus.overflow), 0);
    rst_n = 1'b1;

    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(1'b0, 16'h0F0F, 16'h1111, 1'b1, 1'b0);
    run_op(1'b1, 16'h1000, 16'h1000, 1'b0, 1'b1);

    // Reset during the second RUN cycle abandons the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.op_a = 16'h4321; bus.op_b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", longint'(bus.busy), 0);
    check_eq("midrst_done", longint'(bus.done), 0);
    check_eq("midrst_result", longint'(bus.result), 0);
    for (int k = 0; k < NIB + 2; k++) begin
      @(negedge clk);
      check_eq("midrst_no_done", longint'(bus.done), 0);
    end
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
